lsu_mem_master: RTL

LSU_MEM_MASTER -- requirements
Module: lsu_mem_master

---
 rtl/lsu_mem_master.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: single-outstanding load/store bridge from a MIPS-style core
// to a word-wide memory port. Handles byte/halfword lane steering, load
// sign/zero extension, an ack timeout and illegal-opcode error responses.
// Optional build macro: LSU_MISALIGN_TRAP_EN -- misaligned halfword/word
// accesses return an error instead of being forced to natural alignment.
module lsu_mem_master #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DATA_W = 32;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [5:0]          op_q, op_d;
  logic [1:0]          lane_q, lane_d;

  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [3:0]          mem_be_q, mem_be_d;
  logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  size_e               op_size_c;
  logic                op_legal_c;
  logic                op_store_c;
  logic                req_ok_c;
  logic [DATA_W-1:0]   aligned_addr_c;
  logic [3:0]          be_c;
  logic [DATA_W-1:0]   wdata_c;
  logic [7:0]          load_byte_c;
  logic [15:0]         load_half_c;
  logic [DATA_W-1:0]   load_data_c;
  logic                timeout_hit_c;

  // Decode the incoming opcode into legality, direction and access size
  always_comb begin
    op_size_c  = SZ_WORD;
    op_legal_c = 1'b1;
    op_store_c = 1'b0;
    unique case (req_op)
      OP_LB, OP_LBU: op_size_c = SZ_BYTE;
      OP_LH, OP_LHU: op_size_c = SZ_HALF;
      OP_LW:         op_size_c = SZ_WORD;
      OP_SB: begin
        op_size_c  = SZ_BYTE;
        op_store_c = 1'b1;
      end
      OP_SH: begin
        op_size_c  = SZ_HALF;
        op_store_c = 1'b1;
      end
      OP_SW: begin
        op_size_c  = SZ_WORD;
        op_store_c = 1'b1;
      end
      default: op_legal_c = 1'b0;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // Misaligned halfword/word requests are refused without touching memory
  always_comb begin
    aligned_addr_c = req_addr;
    req_ok_c       = op_legal_c;
    if ((op_size_c == SZ_HALF) && req_addr[0]) begin
      req_ok_c = 1'b0;
    end
    if ((op_size_c == SZ_WORD) && (req_addr[1:0] != 2'b00)) begin
      req_ok_c = 1'b0;
    end
  end
`else
  // Misaligned halfword/word requests are forced to natural alignment
  always_comb begin
    aligned_addr_c = req_addr;
    req_ok_c       = op_legal_c;
    if (op_size_c == SZ_HALF) begin
      aligned_addr_c = {req_addr[31:1], 1'b0};
    end else if (op_size_c == SZ_WORD) begin
      aligned_addr_c = {req_addr[31:2], 2'b00};
    end
  end
`endif

  // Byte enables and replicated write data for the accepted request
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = '0;
    if (op_store_c) begin
      unique case (op_size_c)
        SZ_BYTE: begin
          be_c    = 4'b0001 << aligned_addr_c[1:0];
          wdata_c = {4{req_wdata[7:0]}};
        end
        SZ_HALF: begin
          be_c    = aligned_addr_c[1] ? 4'b1100 : 4'b0011;
          wdata_c = {2{req_wdata[15:0]}};
        end
        default: begin
          be_c    = 4'b1111;
          wdata_c = req_wdata;
        end
      endcase
    end
  end

  // Extract and extend the addressed lane from the returned word
  always_comb begin
    unique case (lane_q)
      2'd0:    load_byte_c = mem_rdata[7:0];
      2'd1:    load_byte_c = mem_rdata[15:8];
      2'd2:    load_byte_c = mem_rdata[23:16];
      default: load_byte_c = mem_rdata[31:24];
    endcase
    load_half_c = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    unique case (op_q)
      OP_LB:   load_data_c = {{24{load_byte_c[7]}}, load_byte_c};
      OP_LBU:  load_data_c = {24'h000000, load_byte_c};
      OP_LH:   load_data_c = {{16{load_half_c[15]}}, load_half_c};
      OP_LHU:  load_data_c = {16'h0000, load_half_c};
      OP_LW:   load_data_c = mem_rdata;
      default: load_data_c = '0;
    endcase
  end

  assign timeout_hit_c = ((cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT));

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    lane_d      = lane_q;
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_be_d    = 4'b0000;
    mem_addr_d  = '0;
    mem_wdata_d = '0;

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          if (!req_ok_c) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d     = ACCESS;
            cnt_d       = '0;
            op_d        = req_op;
            lane_d      = aligned_addr_c[1:0];
            mem_req_d   = 1'b1;
            mem_we_d    = op_store_c;
            mem_be_d    = be_c;
            mem_addr_d  = {aligned_addr_c[31:2], 2'b00};
            mem_wdata_d = wdata_c;
          end
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = op_q[3] ? '0 : load_data_c;
        end else if (timeout_hit_c) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d       = cnt_q + CNT_W'(1);
          mem_req_d   = 1'b1;
          mem_we_d    = mem_we_q;
          mem_be_d    = mem_be_q;
          mem_addr_d  = mem_addr_q;
          mem_wdata_d = mem_wdata_q;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready_d = (state_d == IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      lane_q      <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      lane_q      <= lane_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
